// File: rtl/axis_packet_gen.sv
// AXI-Stream framed test-packet source: counter payload by default,
// PRBS-31 payload when AXIS_PACKET_GEN_PRBS_EN is defined.
module axis_packet_gen #(
  parameter int          LEN_W     = 16,
  parameter int          GAP_W     = 8,
  parameter logic [31:0] PRBS_SEED = 32'h0000_0001
) (
  input  logic             s_axis_clk,
  input  logic             s_axis_reset,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [15:0]      cfg_count,
  output logic             status_busy,
  output logic [15:0]      status_pkt_cnt,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  output logic [31:0]      m_axis_data,
  input  logic             m_axis_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_idx;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      count_q;
  logic [15:0]      pkt_cnt;
  logic             stop_pend;
  logic [31:0]      payload;

  logic start_ok;
  logic beat_ok;
  logic last_beat;
  logic pkt_done;
  logic run_end;
  logic gap_end;

  assign start_ok  = (state == IDLE) && cfg_start;
  assign beat_ok   = (state == SEND) && m_axis_ready;
  assign last_beat = beat_idx == len_q - 1'b1;
  assign pkt_done  = beat_ok && last_beat;
  assign gap_end   = gap_cnt == gap_q - 1'b1;
  // a stop arriving on the final beat itself also ends the run
  assign run_end   = ((count_q != 16'd0) && (pkt_cnt + 16'd1 == count_q))
                   || stop_pend || cfg_stop;

  always_ff @(posedge s_axis_clk) begin
    if (s_axis_reset) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cfg_start) state_nx = SEND;
      SEND: begin
        if (pkt_done) begin
          if (run_end)              state_nx = IDLE;
          else if (gap_q == '0)     state_nx = SEND;
          else                      state_nx = GAP;
        end
      end
      GAP: begin
        if (cfg_stop)     state_nx = IDLE;
        else if (gap_end) state_nx = SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_axis_valid = (state == SEND);
    m_axis_last  = (state == SEND) && last_beat;
    m_axis_data  = (state == SEND) ? payload : 32'd0;
    status_busy  = (state != IDLE);
  end

  assign status_pkt_cnt = pkt_cnt;

  always_ff @(posedge s_axis_clk) begin
    if (s_axis_reset) begin
      len_q     <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      beat_idx  <= '0;
      gap_cnt   <= '0;
      pkt_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (start_ok) begin
        len_q     <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        gap_q     <= cfg_gap;
        count_q   <= cfg_count;
        beat_idx  <= '0;
        pkt_cnt   <= '0;
        stop_pend <= 1'b0;
      end else begin
        if ((state == SEND) && cfg_stop) stop_pend <= 1'b1;
        if (beat_ok) beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
        if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

`ifdef AXIS_PACKET_GEN_PRBS_EN
  logic [31:0] prbs_q;

  function automatic logic [31:0] prbs_adv(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++) r = {r[30:0], r[30] ^ r[27]};
    return r;
  endfunction

  always_ff @(posedge s_axis_clk) begin
    if (s_axis_reset)  prbs_q <= PRBS_SEED;
    else if (start_ok) prbs_q <= PRBS_SEED;
    else if (beat_ok)  prbs_q <= prbs_adv(prbs_q);
  end

  assign payload = prbs_q;
`else
  assign payload = {pkt_cnt, 16'(beat_idx)};
`endif

endmodule

// File: tb/tb_axis_packet_gen.sv
// Scoreboard bench for axis_packet_gen: framing, gaps, backpressure,
// stop handling and mid-packet reset.
module tb_axis_packet_gen;

  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] cfg_count = '0;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        valid;
  logic        last;
  logic [31:0] data;
  logic        ready = 1'b0;

  axis_packet_gen #(
    .LEN_W    (16),
    .GAP_W    (8),
    .PRBS_SEED(SEED)
  ) dut (
    .s_axis_clk    (clk),
    .s_axis_reset  (rst),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_len       (cfg_len),
    .cfg_gap       (cfg_gap),
    .cfg_count     (cfg_count),
    .status_busy   (busy),
    .status_pkt_cnt(pkt_cnt),
    .m_axis_valid  (valid),
    .m_axis_last   (last),
    .m_axis_data   (data),
    .m_axis_ready  (ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];
  int          gaps[$];
  bit          hold;
  logic [32:0] held;
  int          low;
  bit          first;
  bit          seen;
  int          mon_pkt;
  int          stop_after;
  bit          arm;
  int          rdy_mode;
  int          cyc = 0;
  int          last_hs = 0;
  logic [31:0] mw;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prbs_ref(input logic [31:0] s);
    logic [31:0] w;
    logic        nb;
    w = s;
    for (int i = 0; i < 32; i++) begin
      nb = w[30] ^ w[27];
      w  = (w << 1) | {31'd0, nb};
    end
    return w;
  endfunction

  task automatic push_pkts(input int npkt, input int len);
    logic [31:0] w;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < len; b++) begin
`ifdef AXIS_PACKET_GEN_PRBS_EN
        w  = mw;
        mw = prbs_ref(mw);
`else
        w = {p[15:0], b[15:0]};
`endif
        sb.push_back({(b == len - 1), w});
      end
    end
  endtask

  task automatic monitor();
    cyc++;
    if (rst) begin
      hold = 1'b0;
      return;
    end
    if (valid) begin
      if (hold) check("hold", {last, data}, held);
      if (ready) begin
        hold = 1'b0;
        if (sb.size() == 0) check("extra_beat", {last, data}, 64'h1_DEAD_BEEF);
        else check("beat", {last, data}, sb.pop_front());
        if (first && seen) gaps.push_back(low);
        low     = 0;
        seen    = 1'b1;
        first   = last;
        last_hs = cyc;
        if (last) begin
          if (mon_pkt == stop_after) arm = 1'b1;
          mon_pkt++;
        end
      end else begin
        hold = 1'b1;
        held = {last, data};
      end
    end else begin
      if (hold) begin
        check("valid_drop", 0, 1);
        hold = 1'b0;
      end
      if (busy) low++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cfg_stop = arm;
    arm      = 1'b0;
    case (rdy_mode)
      1:       ready = 1'($urandom_range(0, 1));
      2:       ready = 1'b0;
      default: ready = 1'b1;
    endcase
  endtask

  task automatic mon_reset(input int stop_aft);
    mw = SEED;
    sb.delete();
    gaps.delete();
    hold       = 1'b0;
    low        = 0;
    first      = 1'b1;
    seen       = 1'b0;
    mon_pkt    = 0;
    stop_after = stop_aft;
  endtask

  task automatic run(input int len, input int gap, input int cnt,
                     input int npkt, input int stop_aft,
                     input int idle_lat, input int rmode);
    int n;
    cfg_len   = 16'(len);
    cfg_gap   = 8'(gap);
    cfg_count = 16'(cnt);
    rdy_mode  = rmode;
    mon_reset(stop_aft);
    push_pkts(npkt, (len == 0) ? 1 : len);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_len   = 16'd9;
    cfg_gap   = 8'd1;
    cfg_count = 16'd7;
    check("busy_on", busy, 1);
    check("valid_on", valid, 1);
    n = 0;
    while (busy && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) check("timeout", 1, 0);
    check("idle_lat", cyc - last_hs, idle_lat - 1);
    check("valid_idle", valid, 0);
    check("sb_empty", sb.size(), 0);
    check("pkt_cnt", pkt_cnt, npkt);
  endtask

  initial begin
    rdy_mode = 0;
    mon_reset(-1);
    arm = 1'b0;
    repeat (3) step();
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", pkt_cnt, 0);
    rst = 1'b0;
    step();

    run(4, 0, 2, 2, -1, 1, 0);
    check("b2b_gaps_n", gaps.size(), 1);
    if (gaps.size() > 0) check("b2b_gap", gaps[0], 0);

    run(3, 5, 2, 2, -1, 1, 0);
    check("gap5_n", gaps.size(), 1);
    if (gaps.size() > 0) check("gap5", gaps[0], 5);

    run(4, 0, 2, 2, -1, 1, 1);

    run(2, 0, 0, 3, 1, 1, 0);

    run(2, 10, 0, 1, 0, 2, 0);

    run(0, 0, 3, 3, -1, 1, 0);
    check("len0_gaps_n", gaps.size(), 2);

`ifdef AXIS_PACKET_GEN_PRBS_EN
    run(16, 0, 1, 1, -1, 1, 0);
    run(16, 0, 1, 1, -1, 1, 0);
`endif

    cfg_len   = 16'd4;
    cfg_gap   = 8'd0;
    cfg_count = 16'd0;
    rdy_mode  = 0;
    mon_reset(-1);
    push_pkts(1, 4);
    void'(sb.pop_back());
    void'(sb.pop_back());
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    step();
    rdy_mode = 2;
    ready    = 1'b0;
    rst      = 1'b1;
    step();
    check("mid_valid", valid, 0);
    check("mid_last", last, 0);
    check("mid_data", data, 0);
    check("mid_busy", busy, 0);
    check("mid_cnt", pkt_cnt, 0);
    check("mid_sb", sb.size(), 0);
    rst = 1'b0;
    rdy_mode = 0;
    step();
    run(4, 0, 1, 1, -1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
